// File: rtl/neuron_sequencer_pkg.sv
// Shared types and constants for the neuron sequencer: FSM state encoding,
// result width, saturation bounds and the ReLU helper.
package neuron_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        BIAS  = 3'd2,
        ACT   = 3'd3,
        OUT   = 3'd4
    } state_e;

    localparam int RELU_W  = 18;
    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;

    // Negative inputs (sign bit set) map to zero, everything else passes through.
    function automatic logic [RELU_W-1:0] relu_f(input logic [RELU_W-1:0] val);
        logic [RELU_W-1:0] res;
        if (val[RELU_W-1]) begin
            res = {RELU_W{1'b0}};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Stream interface between the input/weight feeder, the neuron sequencer and
// the next layer: start/bias, (x, w) pair stream and the result stream.
interface neuron_sequencer_if #(
    parameter int N_INPUTS = 4,
    parameter int DW       = 9
);
    import neuron_pkg::*;

    localparam int CW = $clog2(N_INPUTS + 1);

    logic                     start;
    logic signed [RELU_W-1:0] bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DW-1:0]     in_x;
    logic signed [DW-1:0]     in_w;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [RELU_W-1:0] out_data;
    logic                     busy;
    logic [CW-1:0]            count;

    modport master (
        output start, bias, in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_data, busy, count
    );

    modport slave (
        input  start, bias, in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_data, busy, count
    );

endinterface

// File: rtl/neuron_sequencer_relu.sv
// Registered ReLU stage: captures relu(in) on every rising edge, clears on reset.
module relu_stage
    import neuron_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RELU_W-1:0] in,
    output logic [RELU_W-1:0] out
);

    logic [RELU_W-1:0] out_r;

    // Result register, loaded unconditionally so it follows the frozen accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= {RELU_W{1'b0}};
        end else begin
            out_r <= relu_f(in);
        end
    end

    assign out = out_r;

endmodule

// File: rtl/neuron_sequencer.sv
// Single-neuron evaluator: shared MAC over N_INPUTS pairs, bias add, clip, ReLU.
// Optional macro NEURON_SAT_EN selects saturating clip instead of wrap-around.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DW       = 9,
    parameter int ACC_W    = 24
) (
    input  logic               clk,
    input  logic               rst,
    neuron_sequencer_if.slave  bus
);

    localparam int CW = $clog2(N_INPUTS + 1);
    localparam int PW = 2 * DW;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);

    state_e                   state_r;
    state_e                   state_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_s;
    logic [CW-1:0]            count_r;
    logic [CW-1:0]            count_s;
    logic signed [RELU_W-1:0] bias_r;
    logic signed [RELU_W-1:0] bias_s;
    logic                     in_ready_r;
    logic                     busy_r;
    logic                     out_valid_r;
    logic                     handshake_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  bias_ext_s;
    logic [RELU_W-1:0]        clip_s;
    logic [RELU_W-1:0]        relu_out_s;

    assign handshake_s = bus.in_valid && in_ready_r;
    assign prod_s      = bus.in_x * bus.in_w;
    assign prod_ext_s  = {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
    assign bias_ext_s  = {{(ACC_W-RELU_W){bias_r[RELU_W-1]}}, bias_r};

    // Next-state, accumulator, counter and bias-capture logic.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        count_s = count_r;
        bias_s  = bias_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    bias_s  = bus.bias;
                    acc_s   = {ACC_W{1'b0}};
                    count_s = {CW{1'b0}};
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (handshake_s) begin
                    acc_s   = acc_r + prod_ext_s;
                    count_s = count_r + CW'(1);
                    if (count_r == LAST_IDX) begin
                        state_s = BIAS;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            BIAS: begin
                acc_s   = acc_r + bias_ext_s;
                state_s = ACT;
            end
            ACT: begin
                state_s = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output-flag registers; flags decode the next state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= {CW{1'b0}};
            bias_r      <= {RELU_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            count_r     <= count_s;
            bias_r      <= bias_s;
            in_ready_r  <= (state_s == ACCUM);
            busy_r      <= (state_s != IDLE);
            out_valid_r <= (state_s == OUT);
        end
    end

`ifdef NEURON_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX_ACC = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN_ACC = ACC_W'(SAT_MIN);

    // Saturate the accumulator into the 18-bit signed result range.
    always_comb begin
        if (acc_r > SAT_MAX_ACC) begin
            clip_s = RELU_W'(SAT_MAX);
        end else if (acc_r < SAT_MIN_ACC) begin
            clip_s = RELU_W'(SAT_MIN);
        end else begin
            clip_s = acc_r[RELU_W-1:0];
        end
    end
`else
    // Wrap-around clip: keep the low 18 bits of the accumulator.
    always_comb begin
        clip_s = acc_r[RELU_W-1:0];
    end
`endif

    relu_stage u_relu (
        .clk (clk),
        .rst (rst),
        .in  (clip_s),
        .out (relu_out_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = relu_out_s;
    assign bus.count     = count_r;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer: vector table plus hold and reset-abort sequences.
module tb_neuron_sequencer;

    localparam int N_INPUTS = 4;
    localparam int DW       = 9;
    localparam int ACC_W    = 24;

    typedef struct {
        int x[4];
        int w[4];
        int bias;
        int gap[4];
        int exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[5];

    neuron_sequencer_if #(.N_INPUTS(N_INPUTS), .DW(DW)) bus ();

    neuron_sequencer #(.N_INPUTS(N_INPUTS), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts an evaluation at the current negedge, feeds the pairs and waits for out_valid.
    task automatic run_eval(input vec_t v, input bit do_release);
        int lat;
        int bound;
        bus.start    = 1'b1;
        bus.bias     = 18'(v.bias);
        bus.in_valid = 1'b1;
        bus.in_x     = 9'sd7;
        bus.in_w     = 9'sd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            for (int g = 0; g < v.gap[i]; g++) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                check("count_in_gap", int'(bus.count), i);
            end
            bus.in_valid = 1'b1;
            bus.in_x     = DW'(v.x[i]);
            bus.in_w     = DW'(v.w[i]);
            bound = 0;
            while (!bus.in_ready && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            check("in_ready", int'(bus.in_ready), 1);
            check("count_step", int'(bus.count), i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        check("out_data", int'(bus.out_data), v.exp_data);
        check("count_done", int'(bus.count), N_INPUTS);
        if (do_release) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("out_valid_after", int'(bus.out_valid), 0);
            check("busy_after", int'(bus.busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, 0, '{0, 0, 0, 0}, 10};
        vecs[1] = '{'{-5, -5, -5, -5}, '{3, 3, 3, 3}, 10, '{0, 0, 0, 0}, 0};
`ifdef NEURON_SAT_EN
        vecs[2] = '{'{255, 255, 255, 255}, '{255, 255, 255, 255}, 131071, '{0, 0, 0, 0}, 131071};
`else
        vecs[2] = '{'{255, 255, 255, 255}, '{255, 255, 255, 255}, 131071, '{0, 0, 0, 0}, 129027};
`endif
        vecs[3] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, 0, '{1, 3, 0, 2}, 10};
        vecs[4] = '{'{-3, 4, -2, 7}, '{-2, 5, 6, 1}, -1, '{0, 2, 0, 1}, 20};

        bus.start     = 1'b0;
        bus.bias      = 18'sd0;
        bus.in_valid  = 1'b0;
        bus.in_x      = 9'sd0;
        bus.in_w      = 9'sd0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_count", int'(bus.count), 0);

        for (int k = 0; k < 5; k++) begin
            run_eval(vecs[k], 1'b1);
        end

        // Hold the result with out_ready low while start is pulsed.
        run_eval(vecs[0], 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k % 2 == 0);
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_out_data", int'(bus.out_data), 10);
            check("hold_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("hold_busy_after", int'(bus.busy), 0);
        check("hold_in_ready_after", int'(bus.in_ready), 0);
        @(negedge clk);
        check("hold_still_idle", int'(bus.busy), 0);

        // Abort mid-evaluation with a reset after two handshakes.
        bus.start = 1'b1;
        bus.bias  = 18'sd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 9'(i + 1);
            bus.in_w     = 9'sd1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("abort_count_pre", int'(bus.count), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_in_ready", int'(bus.in_ready), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_out_data", int'(bus.out_data), 0);
        check("abort_count", int'(bus.count), 0);
        repeat (4) @(negedge clk);
        check("abort_no_result", int'(bus.out_valid), 0);
        run_eval(vecs[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
